// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/start request and result/status bundle for the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B, LSB first, one full-subtractor cell plus a borrow flop
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  sub
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, amsb_q, bmsb_q, borrow_q, ovf_q;
  logic             d, br_d, load, last;
  always_comb begin
    d    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_d = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    load = sub.start && state_q != RUN;
    last = state_q == RUN && cnt_q == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = load ? RUN : state_q == RUN ? (last ? DONE : RUN) : IDLE;
  // a_sr doubles as the result shifter: difference bits enter at the MSB as minuend bits leave
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      a_sr_q <= sub.a;
      b_sr_q <= sub.b;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      amsb_q <= sub.a[WIDTH-1];
      bmsb_q <= sub.b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sr_q <= {d, a_sr_q[WIDTH-1:1]};
      b_sr_q <= b_sr_q >> 1;
      br_q   <= br_d;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        diff_q   <= {d, a_sr_q[WIDTH-1:1]};
        borrow_q <= br_d;
        ovf_q    <= (amsb_q ^ bmsb_q) & (amsb_q ^ d);
      end
    end
  always_comb begin
    sub.busy   = state_q == RUN;
    sub.done   = state_q == DONE;
    sub.diff   = diff_q;
    sub.borrow = borrow_q;
    sub.ovf    = ovf_q;
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors checked against an arithmetic reference model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  serial_subtractor_if #(.WIDTH(8)) sif ();
  serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .sub(sif.slave));
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: an accepted request yields (a-b) and flags 8 cycles later, shown for one cycle as done
  int         m_left;
  logic       m_done, m_borrow, m_ovf, p_borrow, p_ovf;
  logic [7:0] m_diff, p_diff;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_diff   <= 8'h00;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (sif.start) begin
        m_left   <= 8;
        p_diff   <= sif.a - sif.b;
        p_borrow <= sif.a < sif.b;
        p_ovf    <= ((int'($signed(sif.a)) - int'($signed(sif.b))) > 127) ||
                    ((int'($signed(sif.a)) - int'($signed(sif.b))) < -128);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done   <= 1'b1;
        m_diff   <= p_diff;
        m_borrow <= p_borrow;
        m_ovf    <= p_ovf;
      end
    end
  always @(negedge clk)
    if (!rst) begin
      chk("busy", sif.busy, m_left != 0);
      chk("done", sif.done, m_done);
      chk("diff", sif.diff, m_diff);
      chk("borrow", sif.borrow, m_borrow);
      chk("ovf", sif.ovf, m_ovf);
    end
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = a;
    sif.b = b;
    @(negedge clk);
    sif.start = 1'b0;
    sif.a = 8'($urandom);
    sif.b = 8'($urandom);
  endtask
  task automatic wait_done(input string name, input logic [7:0] ed, input logic eb, input logic eo,
                           input int ebusy);
    int  busy_n = 0;
    bit  seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sif.busy) busy_n++;
      if (sif.done) seen = 1;
      else @(negedge clk);
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    chk({name, "_busy_cycles"}, busy_n, ebusy);
    chk({name, "_diff"}, sif.diff, ed);
    chk({name, "_borrow"}, sif.borrow, eb);
    chk({name, "_ovf"}, sif.ovf, eo);
  endtask
  task automatic check_zero(input string name);
    chk({name, "_busy"}, sif.busy, 0);
    chk({name, "_done"}, sif.done, 0);
    chk({name, "_diff"}, sif.diff, 0);
    chk({name, "_borrow"}, sif.borrow, 0);
    chk({name, "_ovf"}, sif.ovf, 0);
  endtask
  initial begin
    int t, last, pulses;
    sif.start = 1'b0;
    sif.a = 8'h00;
    sif.b = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    launch(8'h2D, 8'h0F); wait_done("t1", 8'h1E, 1'b0, 1'b0, 8);
    launch(8'h05, 8'h07); wait_done("t2a", 8'hFE, 1'b1, 1'b0, 8);
    launch(8'h80, 8'h01); wait_done("t2b", 8'h7F, 1'b0, 1'b1, 8);
    launch(8'h7F, 8'hFF); wait_done("t3a", 8'h80, 1'b1, 1'b1, 8);
    launch(8'h00, 8'h00); wait_done("t3b", 8'h00, 1'b0, 1'b0, 8);
    launch(8'h7F, 8'hFF); wait_done("t4pre", 8'h80, 1'b1, 1'b1, 8);
    launch(8'h40, 8'h10);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = 8'hFF;
    sif.b = 8'h00;
    chk("t4_hold_diff", sif.diff, 8'h80);
    chk("t4_hold_borrow", sif.borrow, 1);
    @(negedge clk);
    sif.start = 1'b0;
    chk("t4_hold_ovf", sif.ovf, 1);
    wait_done("t4", 8'h30, 1'b0, 1'b0, 6);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = 8'h03;
    sif.b = 8'h01;
    t = 0; last = -1; pulses = 0;
    while (pulses < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (sif.done) begin
        chk("t5_diff", sif.diff, 8'h02);
        chk("t5_busy_in_done", sif.busy, 0);
        if (last >= 0) chk("t5_period", t - last, 9);
        last = t;
        pulses++;
      end
    end
    chk("t5_pulses", pulses, 3);
    sif.start = 1'b0;
    repeat (12) @(negedge clk);
    launch(8'h55, 8'hAA);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("t6_async");
    repeat (3) @(negedge clk);
    check_zero("t6_held");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    launch(8'h10, 8'h20); wait_done("t6", 8'hF0, 1'b1, 1'b0, 8);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
